// File: rtl/adc_capture_pkg.sv
// Shared constants, capture FSM encoding and lane helper
// for the interleaved ADC capture buffer.
package adc_capture_pkg;

  localparam int WAYS       = 8;
  localparam int BITS       = 9;
  localparam int FRAME_W    = WAYS * BITS;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE_ST = 2'd2
  } cap_state_e;

  // lane 0 is the earliest sample in time
  function automatic logic [BITS-1:0] lane_of(
    input logic [FRAME_W-1:0] f,
    input int                 k
  );
    return f[k*BITS +: BITS];
  endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// Synchronous show-ahead frame FIFO with flush.
// The head entry is presented combinationally while not empty.
module adc_frame_fifo #(
  parameter  int W     = 72,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign level = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  // a full FIFO still accepts a push when the head leaves
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// Receive end of the 8-way interleaved SAR ADC: registers lanes,
// frames them and buffers armed captures into a stream FIFO.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter  int WAYS       = 8,
  parameter  int BITS       = 9,
  parameter  int FIFO_DEPTH = 16,
  parameter  int CNT_W      = 16,
  localparam int FW         = WAYS * BITS,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             ADCCLK,
  input  logic             RSTN,
  input  logic [FW-1:0]    ADCIN,
  input  logic             TWOS,
  input  logic             ARM,
  input  logic             ABORT,
  input  logic             CLR,
  input  logic [CNT_W-1:0] NFRAMES,
  output logic [FW-1:0]    DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [LW-1:0]    LEVEL
);

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nf_q, nf_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [FW-1:0]    in_q, in_d;
  logic             tag_q, tag_d;
  logic [FW-1:0]    s2_q, s2_d;
  logic             s2v_q, s2v_d;
  logic             full;
  logic             empty;

  always_comb begin
    in_d = ADCIN;
    for (int k = 0; k < WAYS; k++) begin
      in_d[k*BITS+BITS-1] = ADCIN[k*BITS+BITS-1] ^ TWOS;
    end
  end

  // capture tag follows the frame; a flush kills both in-flight frames
  always_comb begin
    tag_d = (state_q == CAPTURE) && !CLR;
    s2_d  = in_q;
    s2v_d = tag_q && !CLR;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nf_d    = nf_q;
    done_d  = done_q;
    if (CLR) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (ABORT) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE_ST: begin
          if (ARM) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            nf_d    = NFRAMES;
            done_d  = 1'b0;
          end
        end
        CAPTURE: begin
          cnt_d = cnt_q + 1'b1;
          if (nf_q != '0 && cnt_q == CNT_W'(nf_q - 1'b1)) begin
            state_d = DONE_ST;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (CLR) ovf_d = 1'b0;
    else if (s2v_q && full && !DREADY) ovf_d = 1'b1;
  end

  always_ff @(posedge ADCCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nf_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      in_q    <= '0;
      tag_q   <= 1'b0;
      s2_q    <= '0;
      s2v_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nf_q    <= nf_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      in_q    <= in_d;
      tag_q   <= tag_d;
      s2_q    <= s2_d;
      s2v_q   <= s2v_d;
    end
  end

  adc_frame_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ADCCLK),
    .rst_n (RSTN),
    .flush (CLR),
    .push  (s2v_q),
    .pop   (DREADY),
    .din   (s2_q),
    .dout  (DOUT),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

  assign DVALID = !empty;
  assign BUSY   = (state_q == CAPTURE);
  assign DONE   = done_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized bench for adc_capture_buffer against a
// frame-queue reference model.
module tb_adc_capture_buffer;
  import adc_capture_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic               ADCCLK = 1'b0;
  logic               RSTN;
  logic [FRAME_W-1:0] ADCIN;
  logic               TWOS;
  logic               ARM;
  logic               ABORT;
  logic               CLR;
  logic [CNT_W-1:0]   NFRAMES;
  logic [FRAME_W-1:0] DOUT;
  logic               DVALID;
  logic               DREADY;
  logic               BUSY;
  logic               DONE;
  logic               OVF;
  logic [LW-1:0]      LEVEL;

  adc_capture_buffer dut (
    .ADCCLK  (ADCCLK),
    .RSTN    (RSTN),
    .ADCIN   (ADCIN),
    .TWOS    (TWOS),
    .ARM     (ARM),
    .ABORT   (ABORT),
    .CLR     (CLR),
    .NFRAMES (NFRAMES),
    .DOUT    (DOUT),
    .DVALID  (DVALID),
    .DREADY  (DREADY),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVF     (OVF),
    .LEVEL   (LEVEL)
  );

  always #5 ADCCLK = ~ADCCLK;

  int nvec = 0;
  int nerr = 0;

  logic [FRAME_W-1:0] mq [$];
  bit                 m_cap, m_done, m_ovf, m_cont;
  int                 m_left;
  bit                 p1v, p2v;
  logic [FRAME_W-1:0] p1d, p2d;

  task automatic chk(input string tag,
                     input logic [FRAME_W-1:0] got,
                     input logic [FRAME_W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] conv(input logic [FRAME_W-1:0] a,
                                              input logic t);
    logic [FRAME_W-1:0] r;
    r = a;
    for (int k = 0; k < WAYS; k++)
      if (t) r[k*BITS+BITS-1] = ~r[k*BITS+BITS-1];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cap  = 0;
    m_done = 0;
    m_ovf  = 0;
    m_cont = 0;
    m_left = 0;
    p1v    = 0;
    p2v    = 0;
    p1d    = '0;
    p2d    = '0;
  endtask

  // one clock edge of the buffer as seen from its ports
  task automatic model_edge();
    bit pop;
    int sz;
    bit np1v;
    logic [FRAME_W-1:0] np1d;
    sz   = mq.size();
    pop  = DREADY && sz != 0;
    np1v = m_cap && !CLR;
    np1d = conv(ADCIN, TWOS);
    if (CLR) begin
      mq.delete();
      m_ovf  = 0;
      m_done = 0;
      m_cap  = 0;
      p1v    = 0;
      p2v    = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (p2v) begin
        if (sz == FIFO_DEPTH && !pop) m_ovf = 1;
        else mq.push_back(p2d);
      end
      p2v = p1v;
      p2d = p1d;
      p1v = np1v;
      p1d = np1d;
      if (ABORT) begin
        m_cap = 0;
      end else if (!m_cap) begin
        if (ARM) begin
          m_cap  = 1;
          m_done = 0;
          m_cont = (NFRAMES == 0);
          m_left = int'(NFRAMES);
        end
      end else if (!m_cont) begin
        m_left--;
        if (m_left == 0) begin
          m_cap  = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("dvalid", FRAME_W'(DVALID), FRAME_W'(mq.size() != 0));
    chk("dout", DOUT, (mq.size() != 0) ? mq[0] : '0);
    chk("level", FRAME_W'(LEVEL), FRAME_W'(mq.size()));
    chk("busy", FRAME_W'(BUSY), FRAME_W'(m_cap));
    chk("done", FRAME_W'(DONE), FRAME_W'(m_done));
    chk("ovf", FRAME_W'(OVF), FRAME_W'(m_ovf));
  endtask

  task automatic step();
    @(posedge ADCCLK);
    if (!RSTN) model_reset();
    else model_edge();
    @(negedge ADCCLK);
    check_all();
  endtask

  task automatic rnd_adc();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    ADCIN = r[FRAME_W-1:0];
  endtask

  task automatic pulse_arm();
    ARM = 1'b1;
    step();
    ARM = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
  endtask

  initial begin
    RSTN    = 1'b0;
    ADCIN   = '0;
    TWOS    = 1'b0;
    ARM     = 1'b0;
    ABORT   = 1'b0;
    CLR     = 1'b0;
    NFRAMES = '0;
    DREADY  = 1'b0;
    model_reset();
    step();
    step();
    RSTN = 1'b1;
    step();

    // basic four-frame capture with ramp lanes
    DREADY  = 1'b1;
    NFRAMES = 16'd4;
    for (int t = 0; t < 14; t++) begin
      for (int k = 0; k < WAYS; k++) ADCIN[k*BITS +: BITS] = BITS'(16 * t + k);
      ARM = (t == 0);
      step();
    end
    chk("basic_done", FRAME_W'(DONE), FRAME_W'(1));
    chk("basic_busy", FRAME_W'(BUSY), FRAME_W'(0));

    // offset-binary to two's complement
    DREADY  = 1'b0;
    TWOS    = 1'b1;
    NFRAMES = 16'd1;
    ADCIN   = '0;
    pulse_arm();
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < WAYS; k++)
      chk("twos_zero", FRAME_W'(lane_of(DOUT, k)), FRAME_W'(9'h100));
    DREADY = 1'b1;
    step();
    DREADY = 1'b0;
    ADCIN  = '1;
    pulse_arm();
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < WAYS; k++)
      chk("twos_ones", FRAME_W'(lane_of(DOUT, k)), FRAME_W'(9'h0FF));
    TWOS = 1'b0;
    pulse_clr();

    // overflow under backpressure, then drain
    NFRAMES = 16'd20;
    rnd_adc();
    pulse_arm();
    for (int i = 0; i < 30; i++) begin
      rnd_adc();
      step();
    end
    chk("ovf_level", FRAME_W'(LEVEL), FRAME_W'(FIFO_DEPTH));
    chk("ovf_flag", FRAME_W'(OVF), FRAME_W'(1));
    chk("ovf_done", FRAME_W'(DONE), FRAME_W'(1));
    DREADY = 1'b1;
    for (int i = 0; i < 20; i++) step();
    pulse_clr();

    // full FIFO with simultaneous pop
    DREADY  = 1'b0;
    NFRAMES = '0;
    pulse_arm();
    for (int n = 0; n < 40 && mq.size() < FIFO_DEPTH; n++) begin
      rnd_adc();
      step();
    end
    DREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_adc();
      step();
    end
    chk("fullpop_level", FRAME_W'(LEVEL), FRAME_W'(FIFO_DEPTH));
    chk("fullpop_ovf", FRAME_W'(OVF), FRAME_W'(0));
    pulse_clr();

    // abort a continuous capture, buffered frames survive
    DREADY = 1'b0;
    pulse_arm();
    for (int i = 0; i < 7; i++) begin
      rnd_adc();
      step();
    end
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("abort_busy", FRAME_W'(BUSY), FRAME_W'(0));
    chk("abort_done", FRAME_W'(DONE), FRAME_W'(0));
    chk("abort_kept", FRAME_W'(DVALID), FRAME_W'(1));
    DREADY = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("abort_drained", FRAME_W'(DVALID), FRAME_W'(0));

    // flush wins over arm
    DREADY = 1'b0;
    pulse_arm();
    for (int i = 0; i < 6; i++) begin
      rnd_adc();
      step();
    end
    CLR = 1'b1;
    ARM = 1'b1;
    step();
    CLR = 1'b0;
    ARM = 1'b0;
    chk("clr_level", FRAME_W'(LEVEL), FRAME_W'(0));
    chk("clr_dvalid", FRAME_W'(DVALID), FRAME_W'(0));
    chk("clr_busy", FRAME_W'(BUSY), FRAME_W'(0));
    for (int i = 0; i < 4; i++) step();

    // async reset between edges mid-capture
    NFRAMES = '0;
    DREADY  = 1'b0;
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      rnd_adc();
      step();
    end
    #2 RSTN = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", DOUT, '0);
    chk("rst_dvalid", FRAME_W'(DVALID), FRAME_W'(0));
    chk("rst_busy", FRAME_W'(BUSY), FRAME_W'(0));
    chk("rst_done", FRAME_W'(DONE), FRAME_W'(0));
    chk("rst_ovf", FRAME_W'(OVF), FRAME_W'(0));
    chk("rst_level", FRAME_W'(LEVEL), FRAME_W'(0));
    step();
    RSTN    = 1'b1;
    NFRAMES = 16'd3;
    DREADY  = 1'b1;
    pulse_arm();
    for (int i = 0; i < 10; i++) begin
      rnd_adc();
      step();
    end
    chk("rearm_done", FRAME_W'(DONE), FRAME_W'(1));

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      rnd_adc();
      TWOS    = ($urandom_range(0, 1) != 0);
      DREADY  = ($urandom_range(0, 3) != 0);
      ARM     = ($urandom_range(0, 15) == 0);
      ABORT   = ($urandom_range(0, 40) == 0);
      CLR     = ($urandom_range(0, 60) == 0);
      NFRAMES = CNT_W'($urandom_range(0, 6));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
